// File: rtl/spi_arb_pkg.sv
// Shared types and default sizes for the SPI master arbiter.
package spi_arb_pkg;

  localparam int unsigned SPI_ARB_NUM_REQ    = 4;
  localparam int unsigned SPI_ARB_DATA_WIDTH = 8;
  localparam int unsigned SPI_ARB_IDX_W      = $clog2(SPI_ARB_NUM_REQ);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    DONE   = 2'd3
  } arb_state_e;

endpackage

// File: rtl/spi_rr_pick.sv
// Round-robin pick: first set req bit at or above ptr, wrapping to 0.
module spi_rr_pick
  import spi_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = SPI_ARB_NUM_REQ,
  parameter int unsigned IDX_W   = SPI_ARB_IDX_W
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt_c,
  output logic [IDX_W-1:0]   idx_c,
  output logic               any_c
);

  always_comb begin
    int unsigned j;
    logic        found;
    gnt_c = '0;
    idx_c = '0;
    found = 1'b0;
    j     = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      j = (32'(ptr) + k) % NUM_REQ;
      if (!found && req[IDX_W'(j)]) begin
        found               = 1'b1;
        gnt_c[IDX_W'(j)]    = 1'b1;
        idx_c               = IDX_W'(j);
      end
    end
    any_c = found;
  end

endmodule

// File: rtl/spi_master_arbiter.sv
// Round-robin arbiter sharing one master_spi among NUM_REQ requesters.
// Optional watchdog on the finish wait: define SPI_ARB_TIMEOUT_EN.
module spi_master_arbiter
  import spi_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ        = SPI_ARB_NUM_REQ,
  parameter int unsigned DATA_WIDTH     = SPI_ARB_DATA_WIDTH,
  parameter int unsigned START_HOLD     = 2,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                          clk_m,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_data,
  output logic                          busy,
  output logic                          spi_start,
  output logic [DATA_WIDTH-1:0]         spi_data,
  input  logic                          spi_finish,
  input  logic [DATA_WIDTH-1:0]         spi_data_rx
`ifdef SPI_ARB_TIMEOUT_EN
  ,
  output logic                          timeout_err
`endif
);

  localparam int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CNT_MAX = (START_HOLD > TIMEOUT_CYCLES) ? START_HOLD : TIMEOUT_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  arb_state_e              state_q, state_d;
  logic [IDX_W-1:0]        ptr_q, ptr_d;
  logic [IDX_W-1:0]        win_q, win_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   tx_q, tx_d;
  logic                    fin_q;
  logic [NUM_REQ-1:0]      gnt_q, gnt_d;
  logic [NUM_REQ-1:0]      rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0]   rsp_data_q, rsp_data_d;
  logic                    busy_q, busy_d;
  logic                    spi_start_q, spi_start_d;
  logic [DATA_WIDTH-1:0]   spi_data_q, spi_data_d;
`ifdef SPI_ARB_TIMEOUT_EN
  logic                    timeout_q, timeout_d;
`endif

  logic [NUM_REQ-1:0]      pick_gnt_c;
  logic [IDX_W-1:0]        pick_idx_c;
  logic                    pick_any_c;
  logic                    fin_rise_c;
  logic                    hold_done_c;
  logic                    tmo_hit_c;

  spi_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req   (req),
    .ptr   (ptr_q),
    .gnt_c (pick_gnt_c),
    .idx_c (pick_idx_c),
    .any_c (pick_any_c)
  );

  // Only a fresh 0->1 edge of finish completes a transfer.
  assign fin_rise_c  = spi_finish & ~fin_q;
  assign hold_done_c = (cnt_q == CNT_W'(START_HOLD - 1));
`ifdef SPI_ARB_TIMEOUT_EN
  assign tmo_hit_c   = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign tmo_hit_c   = 1'b0;
`endif

  always_ff @(posedge clk_m or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      win_q       <= '0;
      cnt_q       <= '0;
      tx_q        <= '0;
      fin_q       <= 1'b0;
      gnt_q       <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      busy_q      <= 1'b0;
      spi_start_q <= 1'b0;
      spi_data_q  <= '0;
`ifdef SPI_ARB_TIMEOUT_EN
      timeout_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      win_q       <= win_d;
      cnt_q       <= cnt_d;
      tx_q        <= tx_d;
      fin_q       <= spi_finish;
      gnt_q       <= gnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      busy_q      <= busy_d;
      spi_start_q <= spi_start_d;
      spi_data_q  <= spi_data_d;
`ifdef SPI_ARB_TIMEOUT_EN
      timeout_q   <= timeout_d;
`endif
    end
  end

  // Next state, pointer, winner latch and the hold/watchdog counter.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    tx_d    = tx_q;
    cnt_d   = '0;
    unique case (state_q)
      IDLE: begin
        if (pick_any_c) begin
          state_d = LAUNCH;
          win_d   = pick_idx_c;
          for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (pick_idx_c == IDX_W'(i)) tx_d = req_data[i*DATA_WIDTH +: DATA_WIDTH];
          end
        end
      end
      LAUNCH: begin
        if (hold_done_c) state_d = WAIT;
        else             cnt_d   = cnt_q + CNT_W'(1);
      end
      WAIT: begin
        if (fin_rise_c || tmo_hit_c) state_d = DONE;
        else                         cnt_d   = cnt_q + CNT_W'(1);
      end
      DONE: begin
        state_d = IDLE;
        ptr_d   = (win_q == IDX_W'(NUM_REQ - 1)) ? '0 : win_q + IDX_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    gnt_d       = gnt_q;
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;
    busy_d      = (state_d != IDLE);
    spi_start_d = 1'b0;
    spi_data_d  = '0;
`ifdef SPI_ARB_TIMEOUT_EN
    timeout_d   = timeout_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (pick_any_c) gnt_d = pick_gnt_c;
      end
      LAUNCH: begin
        spi_start_d = 1'b1;
        spi_data_d  = tx_q;
      end
      WAIT: begin
        if (fin_rise_c) begin
          rsp_valid_d = gnt_q;
          rsp_data_d  = spi_data_rx;
        end else if (tmo_hit_c) begin
          rsp_valid_d = gnt_q;
          rsp_data_d  = '0;
`ifdef SPI_ARB_TIMEOUT_EN
          timeout_d   = 1'b1;
`endif
        end
      end
      DONE: gnt_d = '0;
      default: gnt_d = '0;
    endcase
  end

  assign gnt         = gnt_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign busy        = busy_q;
  assign spi_start   = spi_start_q;
  assign spi_data    = spi_data_q;
`ifdef SPI_ARB_TIMEOUT_EN
  assign timeout_err = timeout_q;
`endif

endmodule

// File: doc/spi_master_arbiter.md
Name: spi_master_arbiter

Overview:
Shares one master_spi instance between NUM_REQ independent requesters. Each requester raises a request with a byte to send. The block grants one requester at a time in round-robin order, then drives the master's start and transmit data. It detects completion on the master's finish and returns the received byte to the granted requester with a one-cycle valid pulse. The block sits directly in front of master_spi; its spi_* ports wire straight to master_spi's start, data_in_master, finish and data_out_master.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_WIDTH, 8, SPI word width; must match master_spi
START_HOLD, 2, clk_m cycles spi_start is held high per transfer (>=1)
TIMEOUT_CYCLES, 64, watchdog limit for the wait on finish (only used with SPI_ARB_TIMEOUT_EN)

Ports:
clk_m  in  1  system clock, same clock as master_spi
rst_n  in  1  asynchronous active-low reset
req  in  NUM_REQ  per-requester request level
req_data  in  NUM_REQ*DATA_WIDTH  flattened TX words; requester i at [i*DATA_WIDTH +: DATA_WIDTH]
gnt  out  NUM_REQ  one-hot grant, held for the whole transaction
rsp_valid  out  NUM_REQ  one-cycle pulse to the granted requester when RX data is ready
rsp_data  out  DATA_WIDTH  received word; valid while any rsp_valid bit is high, held until the next capture
busy  out  1  high in any state other than IDLE
spi_start  out  1  to master_spi start
spi_data  out  DATA_WIDTH  to master_spi data_in_master
spi_finish  in  1  from master_spi finish (level; only the rising edge is used)
spi_data_rx  in  DATA_WIDTH  from master_spi data_out_master
timeout_err  out  1  sticky error flag (only exists with SPI_ARB_TIMEOUT_EN)

Behaviour:
- Reset values:
  - State is IDLE; round-robin pointer is 0.
  - gnt, rsp_valid, rsp_data, busy, spi_start, spi_data and timeout_err are all 0.
  - The finish edge-detect register is cleared.
- IDLE:
  - If any req bit is high, select the first set bit searching from the pointer upward with wrap.
  - Register the winner's req_data into tx_reg and set its gnt bit. Go to LAUNCH next cycle.
  - The pointer is not moved at this point.
- LAUNCH:
  - spi_start=1 and spi_data=tx_reg for exactly START_HOLD cycles, then go to WAIT.
  - Outside LAUNCH, spi_start=0 and spi_data=0.
- WAIT:
  - When spi_finish rises (finish=1 and the previous-cycle finish=0), capture spi_data_rx into rsp_data and go to DONE.
  - A finish already high on entry to WAIT does not count; a new 0->1 edge is required.
- DONE (one cycle):
  - rsp_valid[winner]=1.
  - Pointer becomes winner+1 modulo NUM_REQ.
  - gnt is cleared on exit. Return to IDLE.
- Latency: req high in IDLE gives gnt on the next edge, and spi_start on the edge after that.
- Back-to-back operation: IDLE is always visited for at least one cycle between transactions, and arbitration happens there. Minimum gap from rsp_valid to the next spi_start is 2 cycles.
- Requester handshake:
  - A requester holds req and req_data stable until it sees its rsp_valid.
  - If req drops after grant, it is ignored: the transfer completes and rsp_valid still pulses.
- Simultaneous requests: exactly one grant, chosen by pointer order. With all requesters continuously requesting, the grant sequence is 0,1,2,3,0,...
- Pointer wrap: if the winner is NUM_REQ-1, the pointer wraps to 0.
- Reset mid-transaction: everything returns to reset values asynchronously, and spi_start drops immediately. Any pending response is lost.
- gnt is always one-hot or zero.

Optional Feature:
SPI_ARB_TIMEOUT_EN:
- With the macro defined:
  - A counter runs in WAIT.
  - If TIMEOUT_CYCLES elapse without a finish edge, go to DONE, pulse rsp_valid with rsp_data=0, and set timeout_err.
  - timeout_err stays set until reset.
- Without the macro:
  - No counter and no timeout_err port.
  - WAIT lasts indefinitely until a finish edge.

Decomposition:
- Package spi_arb_pkg holds:
  - the state enum (IDLE, LAUNCH, WAIT, DONE);
  - DATA_WIDTH and NUM_REQ defaults;
  - the index width constant $clog2(NUM_REQ).
- Sub-module spi_rr_pick is natural: purely combinational. Inputs are req and the pointer; outputs are a one-hot grant and the winner index. It is instantiated once.

Test Plan:
- Single request: req=4'b0001, req_data[0]=8'hB5, master returns 8'h5A. Expect:
  - gnt=0001 one cycle later, then spi_start high for 2 cycles with spi_data=B5;
  - after finish rises, rsp_valid=0001 for one cycle with rsp_data=5A;
  - busy low again on the following cycle.
- Contention: req=4'b1111 held for 5 transactions. Expect grant order 0,1,2,3,0 and no overlap between gnt bits.
- Pointer wrap and skip: pointer=3 with req=4'b0101. Expect requester 0 granted, then requester 2.
- Early req drop: requester 1 drops req during WAIT. Expect the transfer to complete and rsp_valid[1] to pulse once.
- Reset mid-WAIT: assert rst_n=0 mid-transfer. Expect all outputs 0 asynchronously, and the next request to start from pointer 0.
- Timeout (SPI_ARB_TIMEOUT_EN defined): finish tied low. Expect rsp_valid after 64 WAIT cycles with rsp_data=0, timeout_err=1 and sticky until reset.
